tlul_host_adapter: RTL and testbench
====================================

# tlul_host_adapter

Single-channel TL-UL initiator that turns a simple request/grant memory port into TL-UL A-channel requests and returns D-channel responses as registered read-data/error pulses. It sits on the core/DMA side of the crossbar and drives `tlul_pkg::tl_h2d_t` toward device-side SRAM adapters such as the data memory. It supports up to `Outstanding` in-flight transactions, tags each with a rolling source ID and checks that responses return in order.

## Interface
- `Outstanding`, default 2: maximum in-flight transactions; power of two, 1..16.
- `IdW`, default `$clog2(Outstanding)` (minimum 1): width of the source tag carried in `a_source[IdW-1:0]`.

- `clk_i` in 1: clock. There is one clock.
- `rst_i` in 1: reset. Reset is synchronous and active-high.
- `req_i` in 1: request valid; must stay stable with its payload until `gnt_o`.
- `gnt_o` out 1: request accepted in this cycle.
- `we_i` in 1: 1 = write, 0 = read.
- `addr_i` in 32: byte address; bits [1:0] are ignored.
- `wdata_i` in 32: write data.
- `be_i` in 4: write byte enables.
- `rvalid_o` out 1: one-cycle response pulse, for both reads and writes.
- `rdata_o` out 32: read data, qualified by `rvalid_o`.
- `err_o` out 1: response error, qualified by `rvalid_o`.
- `busy_o` out 1: one or more transactions are outstanding.
- `tl_o` out `tl_h2d_t`: TL-UL host-to-device.
- `tl_i` in `tl_d2h_t`: TL-UL device-to-host.

## Operation
- **A-channel drive.** All fields below are combinational from the request inputs and internal state.
  - `a_valid = req_i & (cnt_q != Outstanding)`.
  - `a_opcode`: Get (4) if `!we_i`; PutFullData (0) if `we_i & be_i==4'hF`; PutPartialData (1) otherwise, including `be_i==0`.
  - `a_size` = 2.
  - `a_mask` = 4'hF for reads, `be_i` for writes.
  - `a_address` = `{addr_i[31:2],2'b00}`.
  - `a_data` = `wdata_i` for writes, 0 for reads.
  - `a_source` = zero-extended `tx_id_q`.
  - `a_param` = 0; `a_user` = `TL_A_USER_DEFAULT`.
- `gnt_o = a_valid & tl_i.a_ready`. On a grant, `tx_id_q` increments modulo `Outstanding` and `cnt_q` increments.
- `d_ready` is tied to 1; responses are never back-pressured.
- **D-channel handshake** (`d_valid`):
  - If `cnt_q` is 0, the response is unexpected: `rvalid_o` pulses with `err_o`=1 and `rdata_o`=0, and `cnt_q` and `rx_id_q` are unchanged.
  - Otherwise `cnt_q` decrements and `rx_id_q` increments modulo `Outstanding`.
  - The response is reported on the next cycle with `err_o = d_error | (d_source[IdW-1:0] != rx_id_q) | (d_opcode` not matching: AccessAckData for a read, AccessAck for a write`)`.
  - To check the opcode, a small shift register (depth `Outstanding`) records `we` per granted transaction, popped in order.
  - `rdata_o` = `d_data` for AccessAckData responses, 0 otherwise.
- **Simultaneous grant and response** in one cycle: `cnt_q` is unchanged, and both IDs and the we-FIFO push and pop.
- **Full** (`cnt_q==Outstanding`): `a_valid`=0 and `gnt_o`=0. If a response arrives in that cycle, a request can be granted on the next cycle; there is no same-cycle bypass.
- `busy_o = (cnt_q != 0)`.

## Timing
- **Reset values:** `cnt_q`=0, `tx_id_q`=0, `rx_id_q`=0, we-FIFO empty, `rvalid_o`=0, `rdata_o`=0, `err_o`=0, `busy_o`=0. `tl_o.a_valid`=0 while `req_i`=0. `tl_o.d_ready`=1 at all times.
- **Reset mid-operation** drops all tracking. Any late responses then arrive with `cnt_q`=0 and are flagged as unexpected errors.
- **Grant latency:** 0 cycles from `req_i` when the device asserts `a_ready` and the adapter is not full.
- **Response latency:** `rvalid_o` is asserted exactly 1 cycle after the `d_valid` cycle. `rdata_o` and `err_o` hold their values until the next response.
- **Back-to-back:** one grant per cycle is sustainable while `cnt_q` is below `Outstanding`.
- **Counter width:** `cnt_q` is `$clog2(Outstanding+1)` bits and never overflows or underflows.

## Test plan
- **Read:** `req_i`=1, `we_i`=0, `addr_i`=32'h0000_0107; device grants in the same cycle and returns AccessAckData with data 32'hDEAD_BEEF two cycles later. Required: `a_address`=32'h104, `a_opcode`=4, `a_mask`=F. `rvalid_o` pulses 1 cycle after `d_valid` with `rdata_o`=DEADBEEF and `err_o`=0.
- **Writes:** `be_i`=F gives `a_opcode`=0; `be_i`=4'b0011 gives `a_opcode`=1 with `a_mask`=3. Each AccessAck produces `rvalid_o` with `err_o`=0 and `rdata_o`=0.
- **Full stall:** with `Outstanding`=2 and `a_ready`=1, three back-to-back requests. Required: grants on cycles 0 and 1; `gnt_o`=0 and `a_valid`=0 on cycle 2 until the first response, then the third request is granted on the following cycle. Sources observed are 0, 1, 0.
- **Response errors:** `d_error`=1 gives `err_o`=1 on the response pulse. A swapped `d_source` (1 returned while 0 is expected) gives `err_o`=1, and `cnt_q` still decrements.
- **Unexpected response:** `d_valid` while idle gives `rvalid_o`=1, `err_o`=1, and `busy_o` stays 0.
- **Reset mid-flight:** two outstanding transactions, then assert `rst_i` for 1 cycle. Required: `busy_o`=0 after reset, and a following stale `d_valid` is reported as an error.

Source files
------------

// File: rtl/tlul_host_adapter.sv
// Minimal TL-UL type package plus a request/grant to TL-UL A/D-channel host adapter.
// Requests are tagged with rolling source IDs, and in-order responses are checked against those IDs.
package tlul_pkg;
  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_DBW = 4;
  localparam int TL_SZW = 2;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic [4:0] rsvd;
    logic [3:0] instr_type;
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  localparam tl_a_user_t TL_A_USER_DEFAULT = '{
    rsvd: 5'h0, instr_type: 4'h9, cmd_intg: 7'h0, data_intg: 7'h0
  };

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  typedef struct packed {
    logic              a_valid;
    tl_a_op_e          a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    tl_a_user_t        a_user;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    tl_d_op_e          d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    tl_d_user_t        d_user;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;
endpackage

module tlul_host_adapter
  import tlul_pkg::*;
#(
  parameter int unsigned Outstanding = 2,
  parameter int unsigned IdW         = (Outstanding > 1) ? $clog2(Outstanding) : 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        busy_o,
  output tl_h2d_t     tl_o,
  input  tl_d2h_t     tl_i
);

  localparam int unsigned CntW = $clog2(Outstanding + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(Outstanding);

  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [IdW-1:0]         tx_id_q, tx_id_d, rx_id_q, rx_id_d;
  logic [Outstanding-1:0] we_q, we_d, we_shift;
  logic [CntW-1:0]        push_idx;
  logic                   rvalid_q, rvalid_d, err_q, err_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   a_valid, grant, pop, exp_we, op_bad;
  logic                   unused_sig;

  function automatic logic [IdW-1:0] id_inc(input logic [IdW-1:0] id);
    if (id == IdW'(Outstanding - 1)) return '0;
    return id + 1'b1;
  endfunction

  assign a_valid  = req_i & (cnt_q != CntMax);
  assign grant    = a_valid & tl_i.a_ready;
  assign pop      = tl_i.d_valid & (cnt_q != '0);
  assign gnt_o    = grant;
  assign busy_o   = (cnt_q != '0);
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

  assign unused_sig = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_user,
                        tl_i.d_source[TL_AIW-1:IdW], addr_i[1:0]};

  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = a_valid;
    tl_o.a_opcode  = !we_i ? Get : (be_i == 4'hF) ? PutFullData : PutPartialData;
    tl_o.a_param   = 3'h0;
    tl_o.a_size    = 2'd2;
    tl_o.a_source  = TL_AIW'(tx_id_q);
    tl_o.a_address = {addr_i[31:2], 2'b00};
    tl_o.a_mask    = we_i ? be_i : 4'hF;
    tl_o.a_data    = we_i ? wdata_i : 32'h0;
    tl_o.a_user    = TL_A_USER_DEFAULT;
    tl_o.d_ready   = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (grant && !pop) cnt_d = cnt_q + 1'b1;
    else if (!grant && pop) cnt_d = cnt_q - 1'b1;
    tx_id_d = grant ? id_inc(tx_id_q) : tx_id_q;
    rx_id_d = pop ? id_inc(rx_id_q) : rx_id_q;

    // Head of the we-FIFO is bit 0; a concurrent pop shifts the push slot down by one.
    we_shift = pop ? (we_q >> 1) : we_q;
    push_idx = cnt_q - CntW'(pop);
    we_d     = we_shift;
    for (int i = 0; i < Outstanding; i++) begin
      if (grant && (push_idx == CntW'(i))) we_d[i] = we_i;
    end

    exp_we   = we_q[0];
    op_bad   = exp_we ? (tl_i.d_opcode != AccessAck) : (tl_i.d_opcode != AccessAckData);
    rvalid_d = tl_i.d_valid;
    rdata_d  = rdata_q;
    err_d    = err_q;
    if (tl_i.d_valid) begin
      if (!pop) begin
        err_d   = 1'b1;
        rdata_d = 32'h0;
      end else begin
        err_d   = tl_i.d_error | (tl_i.d_source[IdW-1:0] != rx_id_q) | op_bad;
        rdata_d = (tl_i.d_opcode == AccessAckData) ? tl_i.d_data : 32'h0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      tx_id_q  <= '0;
      rx_id_q  <= '0;
      we_q     <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      tx_id_q  <= tx_id_d;
      rx_id_q  <= rx_id_d;
      we_q     <= we_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_tlul_host_adapter.sv
// Directed bench for tlul_host_adapter (Outstanding=2) with a hand-driven TL-UL device.
module tb_tlul_host_adapter;
  import tlul_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i, req_i, we_i;
  logic        gnt_o, rvalid_o, err_o, busy_o;
  logic [31:0] addr_i, wdata_i, rdata_o;
  logic [3:0]  be_i;
  tl_h2d_t     tl_h;
  tl_d2h_t     tl_d;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  tlul_host_adapter #(.Outstanding(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .be_i(be_i), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o), .busy_o(busy_o), .tl_o(tl_h), .tl_i(tl_d)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic resp(input tl_d_op_e op, input logic [7:0] src, input logic [31:0] data,
                      input logic derr);
    tl_d.d_valid  = 1'b1;
    tl_d.d_opcode = op;
    tl_d.d_source = src;
    tl_d.d_data   = data;
    tl_d.d_error  = derr;
    step();
    tl_d.d_valid  = 1'b0;
    tl_d.d_error  = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be);
    req_i  = 1'b1;
    we_i   = we;
    addr_i = addr;
    be_i   = be;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; be_i = '0;
    tl_d = '0;
    tl_d.a_ready = 1'b1;
    step(); step();
    rst_i = 1'b0;
    #1;
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_rvalid", 32'(rvalid_o), 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_avalid", 32'(tl_h.a_valid), 0);
    chk("rst_dready", 32'(tl_h.d_ready), 1);

    // Read of 0x107 granted immediately, data returned two cycles later
    issue(1'b0, 32'h0000_0107, 4'h0);
    #1;
    chk("rd_gnt", 32'(gnt_o), 1);
    chk("rd_addr", tl_h.a_address, 32'h104);
    chk("rd_op", 32'(tl_h.a_opcode), 4);
    chk("rd_mask", 32'(tl_h.a_mask), 32'hF);
    chk("rd_size", 32'(tl_h.a_size), 2);
    chk("rd_src", 32'(tl_h.a_source), 0);
    chk("rd_data", tl_h.a_data, 0);
    step();
    req_i = 1'b0;
    chk("rd_busy", 32'(busy_o), 1);
    step();
    resp(AccessAckData, 8'd0, 32'hDEAD_BEEF, 1'b0);
    chk("rd_rvalid", 32'(rvalid_o), 1);
    chk("rd_rdata", rdata_o, 32'hDEAD_BEEF);
    chk("rd_err", 32'(err_o), 0);
    chk("rd_idle", 32'(busy_o), 0);
    step();
    chk("rd_pulse_end", 32'(rvalid_o), 0);
    chk("rd_hold", rdata_o, 32'hDEAD_BEEF);

    // Full-word write
    issue(1'b1, 32'h0000_0200, 4'hF);
    wdata_i = 32'h1234_5678;
    #1;
    chk("wf_op", 32'(tl_h.a_opcode), 0);
    chk("wf_mask", 32'(tl_h.a_mask), 32'hF);
    chk("wf_data", tl_h.a_data, 32'h1234_5678);
    chk("wf_src", 32'(tl_h.a_source), 1);
    step();
    req_i = 1'b0;
    resp(AccessAck, 8'd1, 32'hFFFF_FFFF, 1'b0);
    chk("wf_rvalid", 32'(rvalid_o), 1);
    chk("wf_err", 32'(err_o), 0);
    chk("wf_rdata", rdata_o, 0);

    // Partial write, then an all-zero byte-enable write
    issue(1'b1, 32'h0000_0204, 4'b0011);
    #1;
    chk("wp_op", 32'(tl_h.a_opcode), 1);
    chk("wp_mask", 32'(tl_h.a_mask), 3);
    chk("wp_src", 32'(tl_h.a_source), 0);
    step();
    req_i = 1'b0;
    resp(AccessAck, 8'd0, 32'h0, 1'b0);
    chk("wp_rvalid", 32'(rvalid_o), 1);
    chk("wp_err", 32'(err_o), 0);
    issue(1'b1, 32'h0000_0208, 4'b0000);
    #1;
    chk("wz_op", 32'(tl_h.a_opcode), 1);
    chk("wz_mask", 32'(tl_h.a_mask), 0);
    step();
    req_i = 1'b0;
    resp(AccessAck, 8'd1, 32'h0, 1'b0);
    chk("wz_err", 32'(err_o), 0);

    // Full stall: three back-to-back reads with two slots
    issue(1'b0, 32'h0000_0300, 4'h0);
    #1;
    chk("fs_gnt0", 32'(gnt_o), 1);
    chk("fs_src0", 32'(tl_h.a_source), 0);
    step();
    addr_i = 32'h0000_0304;
    #1;
    chk("fs_gnt1", 32'(gnt_o), 1);
    chk("fs_src1", 32'(tl_h.a_source), 1);
    step();
    addr_i = 32'h0000_0308;
    #1;
    chk("fs_gnt2", 32'(gnt_o), 0);
    chk("fs_av2", 32'(tl_h.a_valid), 0);
    chk("fs_busy", 32'(busy_o), 1);
    step();
    chk("fs_gnt2b", 32'(gnt_o), 0);
    tl_d.d_valid = 1'b1; tl_d.d_opcode = AccessAckData; tl_d.d_source = 8'd0;
    tl_d.d_data = 32'h1111_1111;
    #1;
    chk("fs_nobypass", 32'(gnt_o), 0);
    step();
    tl_d.d_valid = 1'b0;
    chk("fs_r0_data", rdata_o, 32'h1111_1111);
    chk("fs_r0_err", 32'(err_o), 0);
    chk("fs_gnt3", 32'(gnt_o), 1);
    chk("fs_src3", 32'(tl_h.a_source), 0);
    step();
    req_i = 1'b0;
    resp(AccessAckData, 8'd1, 32'h2222_2222, 1'b0);
    chk("fs_r1_err", 32'(err_o), 0);
    chk("fs_r1_busy", 32'(busy_o), 1);
    resp(AccessAckData, 8'd0, 32'h3333_3333, 1'b0);
    chk("fs_r2_data", rdata_o, 32'h3333_3333);
    chk("fs_r2_err", 32'(err_o), 0);
    chk("fs_r2_busy", 32'(busy_o), 0);

    // d_error, swapped source, wrong opcode
    issue(1'b0, 32'h0000_0400, 4'h0);
    step();
    req_i = 1'b0;
    resp(AccessAckData, 8'd1, 32'h0, 1'b1);
    chk("de_rvalid", 32'(rvalid_o), 1);
    chk("de_err", 32'(err_o), 1);
    issue(1'b0, 32'h0000_0404, 4'h0);
    #1;
    chk("sw_src", 32'(tl_h.a_source), 0);
    step();
    req_i = 1'b0;
    resp(AccessAckData, 8'd1, 32'h4444_4444, 1'b0);
    chk("sw_err", 32'(err_o), 1);
    chk("sw_busy", 32'(busy_o), 0);
    issue(1'b1, 32'h0000_0408, 4'hF);
    step();
    req_i = 1'b0;
    resp(AccessAckData, 8'd1, 32'hAAAA_AAAA, 1'b0);
    chk("op_err", 32'(err_o), 1);
    chk("op_rdata", rdata_o, 32'hAAAA_AAAA);

    // Unexpected response while idle
    resp(AccessAckData, 8'd0, 32'h5555_5555, 1'b0);
    chk("ux_rvalid", 32'(rvalid_o), 1);
    chk("ux_err", 32'(err_o), 1);
    chk("ux_rdata", rdata_o, 0);
    chk("ux_busy", 32'(busy_o), 0);

    // Reset with two transactions in flight
    issue(1'b0, 32'h0000_0500, 4'h0);
    step();
    addr_i = 32'h0000_0504;
    step();
    req_i = 1'b0;
    chk("rm_busy_pre", 32'(busy_o), 1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("rm_busy", 32'(busy_o), 0);
    chk("rm_rvalid", 32'(rvalid_o), 0);
    resp(AccessAckData, 8'd0, 32'h6666_6666, 1'b0);
    chk("rm_stale_rvalid", 32'(rvalid_o), 1);
    chk("rm_stale_err", 32'(err_o), 1);
    chk("rm_stale_busy", 32'(busy_o), 0);
    step();
    chk("rm_pulse_end", 32'(rvalid_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
